trace_capture: RTL and testbench
================================

# trace_capture

Hardware commit-trace recorder for the single-cycle MIPS core. Each clock it captures the retiring instruction's pc, instr and register-file write into a FIFO, tagged with a cycle stamp. It drains the FIFO as a stream of 32-bit words over a valid/ready port to a host link (UART/JTAG bridge). It is the on-chip equivalent of the per-cycle pc/instr/regfile dump used in simulation, so board runs can be diffed against `result.txt`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DROP_W`, 16: width of the saturating drop counter.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: capture enable, sampled every cycle.
- `commit` in 1: an instruction retires this cycle.
- `pc` in 32: pc of the retiring instruction.
- `inst` in 32: the retiring instruction word.
- `rf_we` in 1: register-file write enable this cycle.
- `rf_waddr` in 5: destination register.
- `rf_wdata` in 32: write data.
- `tr_valid` out 1: `tr_data` holds a valid word.
- `tr_ready` in 1: consumer accepts the word.
- `tr_data` out 32: trace word.
- `tr_last` out 1: final word of a record.
- `drops` out DROP_W: records lost to overflow; saturates.
- `full` out 1: FIFO full.

## Operation
- Record fields: `{stamp[31:0], pc, inst, rf_we, rf_waddr, rf_wdata}`, 134 bits.
- `stamp` is a free-running 32-bit cycle counter. It is 0 in the first cycle after reset, increments every cycle and wraps 0xFFFFFFFF→0.
- A push happens when `en && commit`. If `rf_we=0`, `rf_waddr` and `rf_wdata` are stored as 0.
- Serialisation is 5 words per record, index `widx` 0..4:
  - W0 = stamp
  - W1 = pc
  - W2 = inst
  - W3 = `{rf_we, 26'b0, rf_waddr}`
  - W4 = rf_wdata; `tr_last=1` only on W4.
- `tr_valid = !empty`. `tr_data` is the head record muxed by `widx`.
- A handshake (`tr_valid && tr_ready`) advances `widx`. On W4, the handshake pops the head and resets `widx` to 0.
- Once `tr_valid` is asserted, `tr_data` stays stable until the handshake. The block never withdraws `tr_valid`.
- Overflow:
  - A push while full and not popping in the same cycle is dropped, and `drops` increments.
  - `drops` saturates at all-ones.
  - When full, a push and a W4 pop in the same cycle are both performed. Nothing is dropped and occupancy is unchanged.
- `en=0` blocks new pushes only. Draining continues.
- Wrap-around: read and write pointers are log2(DEPTH)+1 bits. Full and empty are derived from the MSB comparison.

## Timing
- Reset values: `tr_valid=0`, `tr_data=0`, `tr_last=0`, `drops=0`, `full=0`. Internally `widx=0`, pointers 0, `stamp=0`.
- Reset mid-record discards all FIFO contents and any partial serialisation immediately (asynchronous). No partial record is emitted after reset.
- Latency: a record pushed at edge N shows `tr_valid=1` with W0 in the cycle after edge N. There is no combinational path from `commit` to `tr_valid`.
- Throughput: with `tr_ready` held high, one word per cycle, so one record per 5 cycles. A core committing every cycle therefore overflows in sustained bursts. This is expected and is counted in `drops`.
- `full` is registered and reflects occupancy after the last edge.
- `tr_ready` may be asserted without `tr_valid`; this has no effect.

## Structure
- Shared package `trace_pkg`, containing:
  - the record struct / field offsets
  - `REC_W=134`
  - `WORDS_PER_REC=5`
  - the W3 packing constant
- Sub-module `sync_fifo` (generic: WIDTH, DEPTH, single clock, async reset), with push/pop/full/empty.
- `trace_capture` holds `stamp`, `widx`, the output mux, and the `drops` logic around it.

## Test plan
- **Single record:** after reset, `en=1`, one commit with pc=0x00400000, inst=0x20080005, we=1, waddr=8, wdata=5 at stamp 3; `tr_ready=1`.
  - Expect the words 0x3, 0x00400000, 0x20080005, 0x80000008, 0x5, with `tr_last` on the 5th only.
- **Backpressure:** `tr_ready` toggles 1-0-0-1 mid-record.
  - `tr_data` holds while `tr_ready=0`. The word order is unchanged and no word is duplicated.
- **Overflow:** `tr_ready=0`, DEPTH=16, 20 consecutive commits.
  - Expect `full=1` after the 16th, `drops=4`, and the drained stamps are those of the first 16 records.
- **Full with push and pop in the same cycle:** FIFO full; complete W4 in the same cycle as a commit.
  - `drops` unchanged, occupancy stays 16, and the new record appears last.
- **Reset mid-record:** assert `rst` after W2 is accepted.
  - All outputs are 0 immediately.
  - A following commit emits a fresh W0 whose stamp is relative to the new reset.
- **Counter saturation and wrap:**
  - Force `stamp` to 0xFFFFFFFE and push 3 records → stamps FFFFFFFE, FFFFFFFF, 0.
  - Drive `drops` to saturation with DROP_W=4 → `drops` holds at 0xF.

Source files
------------

// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the commit-trace recorder.
//   trace_rec_t   : one captured commit record (134 bits, MSB = stamp[31])
//   word_idx_t    : serialisation index, W0..W4 in transmit order
//   REC_W         : record width in bits
//   WORDS_PER_REC : number of 32-bit words emitted per record
//   W3_PAD        : zero filler between rf_we and rf_waddr in word W3
//   pack_w3()     : builds the W3 word {rf_we, 26'b0, rf_waddr}
//   rec_word()    : selects one 32-bit word of a record by index
// ---------------------------------------------------------------------------
package trace_pkg;

    localparam int REC_W         = 134;
    localparam int WORDS_PER_REC = 5;
    localparam int WIDX_W        = 3;

    // The 26-bit zero field keeps rf_we in bit 31 and rf_waddr in bits 4:0,
    // which lines W3 up with how the host parser splits the word.
    localparam logic [25:0] W3_PAD = 26'd0;

    // Field order defines the bit offsets: rf_wdata [31:0], rf_waddr [36:32],
    // rf_we [37], inst [69:38], pc [101:70], stamp [133:102].
    typedef struct packed {
        logic [31:0] stamp;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } trace_rec_t;

    typedef enum logic [WIDX_W-1:0] {
        W_STAMP = 3'd0,
        W_PC    = 3'd1,
        W_INST  = 3'd2,
        W_RF    = 3'd3,
        W_DATA  = 3'd4
    } word_idx_t;

    // Index of the word that carries tr_last and pops the record.
    localparam word_idx_t W_LAST = word_idx_t'(WORDS_PER_REC - 1);

    function automatic logic [31:0] pack_w3(input logic we, input logic [4:0] addr);
        return {we, W3_PAD, addr};
    endfunction

    function automatic logic [31:0] rec_word(input trace_rec_t rec, input word_idx_t idx);
        logic [31:0] word;
        word = 32'd0;
        case (idx)
            W_STAMP: word = rec.stamp;
            W_PC:    word = rec.pc;
            W_INST:  word = rec.inst;
            W_RF:    word = pack_w3(rec.rf_we, rec.rf_waddr);
            W_DATA:  word = rec.rf_wdata;
            default: word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with first-word-fall-through read.
//   clk   in  : clock, rising edge
//   rst   in  : asynchronous active-high reset (empties the FIFO)
//   push  in  : write wdata this cycle
//   wdata in  : WIDTH-bit write data
//   pop   in  : discard the head entry this cycle
//   rdata out : head entry (valid while !empty)
//   full  out : DEPTH entries held
//   empty out : no entries held
// A push while full is accepted only if a pop happens in the same cycle, so
// occupancy stays at DEPTH and the freed slot is reused. Pops while empty
// are ignored.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the address
    // bits are equal.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_en;
    logic rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign rd_en = pop && !empty;
    // When full, the slot being written is the head slot that is popped in
    // this same cycle; its old contents have already been consumed.
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Head is read straight from the array so the word is available in the
    // cycle right after the push edge.
    assign rdata = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/trace_capture.sv
// ---------------------------------------------------------------------------
// trace_capture
// Commit-trace recorder: captures each retiring instruction into a FIFO with
// a cycle stamp and streams records out as five 32-bit words.
//   clk      in  : core clock, rising edge
//   rst      in  : asynchronous active-high reset
//   en       in  : capture enable (draining is unaffected)
//   commit   in  : an instruction retires this cycle
//   pc       in  : pc of the retiring instruction
//   inst     in  : retiring instruction word
//   rf_we    in  : register-file write enable
//   rf_waddr in  : destination register
//   rf_wdata in  : register write data
//   tr_valid out : tr_data holds a valid word
//   tr_ready in  : consumer accepts the word
//   tr_data  out : trace word (W0 stamp, W1 pc, W2 inst, W3 rf, W4 wdata)
//   tr_last  out : final word (W4) of a record
//   drops    out : saturating count of records lost to overflow
//   full     out : FIFO full
// STAMP_INIT is the reset value of the cycle stamp; leave it at 0 in normal
// use. A nonzero value lets the stamp wrap be exercised without running
// 2^32 cycles.
// ---------------------------------------------------------------------------
module trace_capture
    import trace_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          DROP_W     = 16,
    parameter logic [31:0] STAMP_INIT = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              commit,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    input  logic              rf_we,
    input  logic [4:0]        rf_waddr,
    input  logic [31:0]       rf_wdata,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [31:0]       tr_data,
    output logic              tr_last,
    output logic [DROP_W-1:0] drops,
    output logic              full
);

    logic [31:0]       stamp_reg;
    word_idx_t         widx_reg;
    logic [DROP_W-1:0] drops_reg;

    trace_rec_t wr_rec;
    trace_rec_t head_rec;
    logic       fifo_empty;
    logic       fifo_full;

    logic push_req;
    logic handshake;
    logic last_word;
    logic pop;
    logic drop;

    // ------------------------------------------------------------------
    // Record assembly. Register-write fields are zeroed when no write
    // happens so the host never sees stale bus values.
    // ------------------------------------------------------------------
    always_comb begin
        wr_rec          = '0;
        wr_rec.stamp    = stamp_reg;
        wr_rec.pc       = pc;
        wr_rec.inst     = inst;
        wr_rec.rf_we    = rf_we;
        wr_rec.rf_waddr = rf_we ? rf_waddr : 5'd0;
        wr_rec.rf_wdata = rf_we ? rf_wdata : 32'd0;
    end

    assign push_req  = en && commit;
    assign tr_valid  = !fifo_empty;
    assign handshake = tr_valid && tr_ready;
    assign last_word = (widx_reg == W_LAST);
    assign pop       = handshake && last_word;
    // A push while full survives only when the head record finishes in the
    // same cycle; the FIFO applies the same rule internally.
    assign drop      = push_req && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Free-running cycle stamp; wraps naturally at 32 bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp_reg <= STAMP_INIT;
        end else begin
            stamp_reg <= stamp_reg + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Word index within the head record. It only moves on a handshake, so
    // tr_data is held stable while the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_reg <= W_STAMP;
        end else if (handshake) begin
            if (last_word) begin
                widx_reg <= W_STAMP;
            end else begin
                widx_reg <= word_idx_t'(widx_reg + 3'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating drop counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drops_reg <= '0;
        end else if (drop && (drops_reg != {DROP_W{1'b1}})) begin
            drops_reg <= drops_reg + DROP_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output word mux. Forced to zero when empty so the bus is quiet after
    // reset and between records.
    // ------------------------------------------------------------------
    always_comb begin
        tr_data = 32'd0;
        if (!fifo_empty) begin
            tr_data = rec_word(head_rec, widx_reg);
        end
    end

    assign tr_last = !fifo_empty && last_word;
    assign drops   = drops_reg;
    assign full    = fifo_full;

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

    logic        clk;
    logic        rst;
    logic        en;
    logic        commit;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_data;
    logic        tr_last;
    logic [15:0] drops;
    logic        full;

    // second instance: small DEPTH, 4-bit drop counter, stamp near wrap
    logic        commit2;
    logic        tr_ready2;
    logic        tr_valid2;
    logic [31:0] tr_data2;
    logic        tr_last2;
    logic [3:0]  drops2;
    logic        full2;

    int checks;
    int failures;

    trace_capture #(.DEPTH(16), .DROP_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .commit(commit), .pc(pc), .inst(inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
        .tr_last(tr_last), .drops(drops), .full(full)
    );

    trace_capture #(.DEPTH(4), .DROP_W(4), .STAMP_INIT(32'hFFFF_FFFE)) dut2 (
        .clk(clk), .rst(rst), .en(en), .commit(commit2), .pc(pc), .inst(inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .tr_valid(tr_valid2), .tr_ready(tr_ready2), .tr_data(tr_data2),
        .tr_last(tr_last2), .drops(drops2), .full(full2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected word w of test record i captured with stamp st.
    // Record i: pc=0x1000+i, inst=0xA0000000|i, rf_we=i[0], waddr=i[4:0], wdata=3*i.
    function automatic logic [31:0] exp_word(input logic [31:0] st, input int i, input int w);
        logic [31:0] iv;
        iv = 32'(i);
        case (w)
            0: return st;
            1: return 32'h0000_1000 + iv;
            2: return 32'hA000_0000 | iv;
            3: return iv[0] ? {1'b1, 26'd0, iv[4:0]} : 32'd0;
            default: return iv[0] ? 32'(i * 3) : 32'd0;
        endcase
    endfunction

    task automatic set_rec(input int i);
        logic [31:0] iv;
        iv       = 32'(i);
        pc       = 32'h0000_1000 + iv;
        inst     = 32'hA000_0000 | iv;
        rf_we    = iv[0];
        rf_waddr = iv[4:0];
        rf_wdata = 32'(i * 3);
    endtask

    // Leaves the bench at a falling edge with rst just released; the next
    // rising edge captures stamp STAMP_INIT.
    task automatic do_reset();
        rst = 1'b1;
        commit = 1'b0;
        commit2 = 1'b0;
        tr_ready = 1'b0;
        tr_ready2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (tr_valid !== 1'b0 || tr_data !== 32'd0 || tr_last !== 1'b0 || drops !== 16'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h last=%b drops=%h full=%b exp all zero",
                     tr_valid, tr_data, tr_last, drops, full);
        end
        checks++;
        if (tr_valid2 !== 1'b0 || tr_data2 !== 32'd0 || drops2 !== 4'd0 || full2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs2 got valid=%b data=%h drops=%h full=%b exp all zero",
                     tr_valid2, tr_data2, drops2, full2);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [31:0] exp_w [5];
        exp_w = '{32'h0000_0003, 32'h0040_0000, 32'h2008_0005, 32'h8000_0008, 32'h0000_0005};
        do_reset();
        en = 1'b1;
        tr_ready = 1'b1;
        repeat (3) @(negedge clk);
        pc = 32'h0040_0000; inst = 32'h2008_0005; rf_we = 1'b1; rf_waddr = 5'd8; rf_wdata = 32'd5;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (tr_valid !== 1'b1 || tr_data !== exp_w[w] || tr_last !== (w == 4)) begin
                failures++;
                $display("FAIL single_w%0d got valid=%b data=%h last=%b exp valid=1 data=%h last=%b",
                         w, tr_valid, tr_data, tr_last, exp_w[w], (w == 4));
            end
            @(negedge clk);
        end
        checks++;
        if (tr_valid !== 1'b0 || tr_data !== 32'd0) begin
            failures++;
            $display("FAIL single_idle got valid=%b data=%h exp valid=0 data=0", tr_valid, tr_data);
        end
        $display("test_single done");
    endtask

    task automatic test_backpressure();
        logic pat [7];
        int k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        k = 0;
        do_reset();
        en = 1'b1;
        set_rec(7);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tr_ready = pat[c];
            checks++;
            if (tr_valid !== 1'b1 || tr_data !== exp_word(32'd0, 7, k) || tr_last !== (k == 4)) begin
                failures++;
                $display("FAIL backpressure_c%0d got valid=%b data=%h last=%b exp valid=1 data=%h last=%b",
                         c, tr_valid, tr_data, tr_last, exp_word(32'd0, 7, k), (k == 4));
            end
            @(negedge clk);
            if (pat[c]) k++;
        end
        checks++;
        if (tr_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_end got valid=%b exp 0", tr_valid);
        end
        tr_ready = 1'b0;
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rec(i);
            commit = 1'b1;
            @(negedge clk);
            checks++;
            if (full !== (i >= 15)) begin
                failures++;
                $display("FAIL overflow_full_push%0d got %b exp %b", i + 1, full, (i >= 15));
            end
        end
        commit = 1'b0;
        checks++;
        if (drops !== 16'd4) begin
            failures++;
            $display("FAIL overflow_drops got %0d exp 4", drops);
        end
        tr_ready = 1'b1;
        for (int r = 0; r < 16; r++) begin
            for (int w = 0; w < 5; w++) begin
                checks++;
                if (tr_valid !== 1'b1 || tr_data !== exp_word(32'(r), r, w) || tr_last !== (w == 4)) begin
                    failures++;
                    $display("FAIL overflow_drain_r%0d_w%0d got valid=%b data=%h last=%b exp data=%h",
                             r, w, tr_valid, tr_data, tr_last, exp_word(32'(r), r, w));
                end
                @(negedge clk);
            end
        end
        checks++;
        if (tr_valid !== 1'b0 || drops !== 16'd4 || full !== 1'b0) begin
            failures++;
            $display("FAIL overflow_end got valid=%b drops=%0d full=%b exp valid=0 drops=4 full=0",
                     tr_valid, drops, full);
        end
        tr_ready = 1'b0;
        $display("test_overflow done");
    endtask

    task automatic test_push_pop_full();
        int idx;
        logic [31:0] st;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_rec(i);
            commit = 1'b1;
            @(negedge clk);
        end
        commit = 1'b0;
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_full_before got %b exp 1", full);
        end
        tr_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (tr_last !== 1'b1 || tr_data !== exp_word(32'd0, 0, 4)) begin
            failures++;
            $display("FAIL pushpop_w4 got last=%b data=%h exp last=1 data=%h",
                     tr_last, tr_data, exp_word(32'd0, 0, 4));
        end
        set_rec(41);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        checks++;
        if (drops !== 16'd0 || full !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_after got drops=%0d full=%b exp drops=0 full=1", drops, full);
        end
        for (int n = 0; n < 16; n++) begin
            idx = (n < 15) ? n + 1 : 41;
            st  = (n < 15) ? 32'(n + 1) : 32'd20;
            for (int w = 0; w < 5; w++) begin
                checks++;
                if (tr_valid !== 1'b1 || tr_data !== exp_word(st, idx, w)) begin
                    failures++;
                    $display("FAIL pushpop_drain_n%0d_w%0d got valid=%b data=%h exp data=%h",
                             n, w, tr_valid, tr_data, exp_word(st, idx, w));
                end
                @(negedge clk);
            end
        end
        checks++;
        if (tr_valid !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_end got valid=%b exp 0", tr_valid);
        end
        tr_ready = 1'b0;
        $display("test_push_pop_full done");
    endtask

    task automatic test_en_gate();
        do_reset();
        en = 1'b0;
        tr_ready = 1'b1;
        set_rec(5);
        commit = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tr_valid !== 1'b0 || drops !== 16'd0) begin
            failures++;
            $display("FAIL en_gate_blocked got valid=%b drops=%0d exp valid=0 drops=0", tr_valid, drops);
        end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (tr_valid !== 1'b1 || tr_data !== exp_word(32'd3, 5, w)) begin
                failures++;
                $display("FAIL en_gate_drain_w%0d got valid=%b data=%h exp data=%h",
                         w, tr_valid, tr_data, exp_word(32'd3, 5, w));
            end
            @(negedge clk);
        end
        checks++;
        if (tr_valid !== 1'b0) begin
            failures++;
            $display("FAIL en_gate_end got valid=%b exp 0", tr_valid);
        end
        commit = 1'b0;
        en = 1'b1;
        tr_ready = 1'b0;
        $display("test_en_gate done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rec(i);
            commit = 1'b1;
            @(negedge clk);
        end
        commit = 1'b0;
        tr_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tr_data !== exp_word(32'd0, 0, 3) || drops !== 16'd4) begin
            failures++;
            $display("FAIL reset_mid_before got data=%h drops=%0d exp data=%h drops=4",
                     tr_data, drops, exp_word(32'd0, 0, 3));
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tr_valid !== 1'b0 || tr_data !== 32'd0 || tr_last !== 1'b0 || drops !== 16'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async got valid=%b data=%h last=%b drops=%0d full=%b exp all zero",
                     tr_valid, tr_data, tr_last, drops, full);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got valid=%b exp 0", tr_valid);
        end
        set_rec(9);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (tr_valid !== 1'b1 || tr_data !== exp_word(32'd2, 9, w) || tr_last !== (w == 4)) begin
                failures++;
                $display("FAIL reset_mid_fresh_w%0d got valid=%b data=%h last=%b exp data=%h",
                         w, tr_valid, tr_data, tr_last, exp_word(32'd2, 9, w));
            end
            @(negedge clk);
        end
        checks++;
        if (tr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_end got valid=%b exp 0", tr_valid);
        end
        tr_ready = 1'b0;
        $display("test_reset_mid done");
    endtask

    task automatic test_wrap_sat();
        logic [31:0] st [3];
        st = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rec(i);
            commit2 = 1'b1;
            @(negedge clk);
        end
        commit2 = 1'b0;
        tr_ready2 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 5; w++) begin
                checks++;
                if (tr_valid2 !== 1'b1 || tr_data2 !== exp_word(st[r], r, w) || tr_last2 !== (w == 4)) begin
                    failures++;
                    $display("FAIL wrap_r%0d_w%0d got valid=%b data=%h last=%b exp data=%h",
                             r, w, tr_valid2, tr_data2, tr_last2, exp_word(st[r], r, w));
                end
                @(negedge clk);
            end
        end
        tr_ready2 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            set_rec(k);
            commit2 = 1'b1;
            @(negedge clk);
            if (k == 18) begin
                checks++;
                if (drops2 !== 4'd14) begin
                    failures++;
                    $display("FAIL sat_drops_k18 got %0d exp 14", drops2);
                end
            end
        end
        commit2 = 1'b0;
        checks++;
        if (drops2 !== 4'hF || full2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_drops_end got drops=%h full=%b exp drops=f full=1", drops2, full2);
        end
        $display("test_wrap_sat done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        en = 1'b0;
        commit = 1'b0;
        commit2 = 1'b0;
        tr_ready = 1'b0;
        tr_ready2 = 1'b0;
        pc = 32'd0;
        inst = 32'd0;
        rf_we = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;

        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_push_pop_full();
        test_en_gate();
        test_reset_mid();
        test_wrap_sat();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
